alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one 32-bit logic/arithmetic unit between two requesters (e.g. main datapath and branch/compare path of the mini MIPS core).
- Round-robin arbitration, operand capture, multi-cycle execution sequencing and a registered result with flags.
- The combinational unit is internal: AND/OR/XOR/NOR/ADD/SUB/SLT/pass.

Parameters:
- WIDTH, 32, operand/result width.
- LAT, 1, number of EXEC cycles (1..15) before the result is registered.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 request.
- op0  input  3  requester 0 opcode.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1  input  1  requester 1 request.
- op1  input  3  requester 1 opcode.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- gnt0  output  1  requester 0 owns the unit.
- gnt1  output  1  requester 1 owns the unit.
- done0  output  1  one-cycle result-valid pulse for requester 0.
- done1  output  1  one-cycle result-valid pulse for requester 1.
- r  output  WIDTH  registered result, shared.
- zero  output  1  r == 0.
- ovf  output  1  signed overflow (ADD/SUB only).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE, gnt0/1=0, done0/1=0, r=0, zero=0, ovf=0, busy=0, exec counter=0, round-robin pointer=0 (requester 0 favoured). Any in-flight operation is discarded and no done is issued for it.
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 ADD, 101 SUB (A−B).
  - 110 SLT (signed; r = {31'b0, A<B}).
  - 111 pass A.
- Widths: ADD/SUB results are truncated to WIDTH. ovf = signed overflow for ADD/SUB and 0 for all other ops.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - Only one request high: grant it.
  - Both high: grant the pointer's requester.
  - On grant, at the same edge: latch op/a/b of the winner, assert its gnt, load counter=LAT−1, go to EXEC.
  - No request: stay in IDLE.
- EXEC:
  - Inputs are ignored; latched operands are used.
  - Counter>0: decrement and stay in EXEC.
  - Counter==0: register r/zero/ovf, assert the winner's done, go to DONE.
- DONE:
  - done high for exactly this cycle; gnt stays high.
  - Next edge: gnt=0, done=0, pointer = the other requester, go to IDLE.
- Timing: request sampled at edge k → gnt high after edge k → done and r valid after edge k+LAT → IDLE after edge k+LAT+1. A new request can first be accepted at edge k+LAT+2. Throughput is one operation per LAT+2 cycles.
- Requester protocol:
  - Hold req and operands stable until done.
  - Deassert req in the done cycle if no further operation is wanted.
  - A req still high when IDLE is next sampled is a new request.
- Outputs and pointer:
  - r/zero/ovf hold their value until the next registered result; they are not cleared on return to IDLE.
  - The pointer changes only on completion; a lone requester is served back-to-back regardless of the pointer.
- Invariants:
  - gnt0 and gnt1 are never high together; done0 and done1 are never high together.
  - done implies the same requester's gnt.

Test Plan:
- Reset check: assert reset mid-cycle, no clock edge → all outputs 0 immediately. Then release reset with no requests for 5 cycles → busy=0, gnt=0.
- Single XOR on requester 0, LAT=1: a0=AAAA_AAAA, b0=5555_5555, op0=010 → gnt0 after edge k, done0 pulse after edge k+1 with r=FFFF_FFFF, zero=0, ovf=0. FFFF_FFFF^FFFF_FFFF → r=0, zero=1.
- Round-robin: req0 and req1 held high continuously after reset → grant sequence 0,1,0,1. done pulses are LAT+2 cycles apart and never overlap.
- Arithmetic flags:
  - ADD 7FFF_FFFF+0000_0001 → r=8000_0000, ovf=1.
  - SUB 8000_0000−1 → r=7FFF_FFFF, ovf=1.
  - SLT FFFF_FFFF,0 → r=1.
  - AND with ovf-triggering operands → ovf=0.
- Multi-cycle and reset abort, LAT=4: done appears exactly 4 edges after grant. A second run asserts reset at the 2nd EXEC cycle → no done is issued, the pointer returns to 0, and the next request is served normally.
- Operand capture: change a0/b0 during EXEC → r reflects the values latched at grant.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares one combinational logic/arithmetic unit between two requesters.
// Round-robin arbitration in IDLE, operand capture at grant, LAT-cycle
// execution and a registered result with zero/overflow flags.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   req0/op0/a0/b0        requester 0 request, opcode, operands
//   req1/op1/a1/b1        requester 1 request, opcode, operands
//   gnt0, gnt1            requester owns the unit (grant through DONE)
//   done0, done1          one-cycle result-valid pulse
//   r, zero, ovf          registered result and flags (held until next result)
//   busy                  FSM not in IDLE
//
// Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB,
//          110 SLT (signed), 111 pass A.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [2:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [2:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;   // favoured requester when both request
  logic             own_q, own_d;   // current owner of the unit
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;

  // Combinational unit, operating only on the latched operands.
  logic [WIDTH-1:0] sum, diff, alu_r;
  logic             alu_ovf;

  assign sum  = a_q + b_q;
  assign diff = a_q - b_q;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (op_q)
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      OP_NOR:  alu_r = ~(a_q | b_q);
      OP_ADD: begin
        alu_r   = sum;
        // Same-sign operands producing an opposite-sign sum.
        alu_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = diff;
        // Different-sign operands where the result sign departs from A.
        alu_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SLT:  alu_r[0] = ($signed(a_q) < $signed(b_q));
      OP_PASS: alu_r = a_q;
      default: alu_r = '0;
    endcase
  end

  logic win;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    win     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // Pointer only matters on contention; a lone requester always wins.
          win     = (req0 && req1) ? ptr_q : req1;
          own_d   = win;
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          cnt_d   = CNT_LOAD;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          r_d     = alu_r;
          zero_d  = (alu_r == '0);
          ovf_d   = alu_ovf;
          done0_d = ~own_q;
          done1_d = own_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ptr_d   = ~own_q;
        state_d = S_IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      own_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign r     = r_q;
  assign zero  = zero_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: instance 0 uses LAT=1, instance 1 LAT=4.
module tb_alu_share_arbiter;

  localparam logic [2:0] AND_ = 3'b000, OR_ = 3'b001, XOR_ = 3'b010, NOR_ = 3'b011;
  localparam logic [2:0] ADD_ = 3'b100, SUB_ = 3'b101, SLT_ = 3'b110, PASS_ = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst, req0, req1;
  logic [2:0]  op0 [2];
  logic [2:0]  op1 [2];
  logic [31:0] a0 [2];
  logic [31:0] b0 [2];
  logic [31:0] a1 [2];
  logic [31:0] b1 [2];
  logic [1:0]  gnt0, gnt1, done0, done1, zero, ovf, busy;
  logic [31:0] r [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_share_arbiter #(.WIDTH(32), .LAT(1)) dut_l1 (
    .clk(clk), .reset(rst[0]),
    .req0(req0[0]), .op0(op0[0]), .a0(a0[0]), .b0(b0[0]),
    .req1(req1[0]), .op1(op1[0]), .a1(a1[0]), .b1(b1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
    .r(r[0]), .zero(zero[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  alu_share_arbiter #(.WIDTH(32), .LAT(4)) dut_l4 (
    .clk(clk), .reset(rst[1]),
    .req0(req0[1]), .op0(op0[1]), .a0(a0[1]), .b0(b0[1]),
    .req1(req1[1]), .op1(op1[1]), .a1(a1[1]), .b1(b1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
    .r(r[1]), .zero(zero[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  typedef struct {
    logic        who;
    logic [31:0] r;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitor: pops expected results on every done pulse.
  int   gcyc [2];
  logic gprev [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic anyg, have;
      exp_t e;
      int   lat;
      if (rst[d] !== 1'b0) begin
        gprev[d] = 1'b0;
      end else begin
        anyg = gnt0[d] | gnt1[d];
        if (anyg && !gprev[d]) gcyc[d] = cyc;
        gprev[d] = anyg;
        checks++;
        if ((gnt0[d] & gnt1[d]) | (done0[d] & done1[d]) |
            (done0[d] & ~gnt0[d]) | (done1[d] & ~gnt1[d])) begin
          failures++;
          $display("FAIL inv%0d: gnt=%b%b done=%b%b, required exclusive and done within own gnt",
                   d, gnt1[d], gnt0[d], done1[d], done0[d]);
        end
        if (done0[d] | done1[d]) begin
          have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
          checks++;
          if (!have) begin
            failures++;
            $display("FAIL unexp_done%0d: got done=%b%b r=%h, required no done", d,
                     done1[d], done0[d], r[d]);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (done1[d] !== e.who || r[d] !== e.r || zero[d] !== e.z || ovf[d] !== e.o) begin
              failures++;
              $display("FAIL result%0d: got who=%0d r=%h z=%b o=%b, required who=%0d r=%h z=%b o=%b",
                       d, done1[d], r[d], zero[d], ovf[d], e.who, e.r, e.z, e.o);
            end
            lat = cyc - gcyc[d];
            checks++;
            if (lat != lat_of(d)) begin
              failures++;
              $display("FAIL latency%0d: got %0d, required %0d", d, lat, lat_of(d));
            end
          end
        end
      end
    end
  end

  task automatic set_req(input int d, input bit who, input logic v, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (who) begin req1[d] = v; op1[d] = op; a1[d] = a; b1[d] = b; end
    else     begin req0[d] = v; op0[d] = op; a0[d] = a; b0[d] = b; end
  endtask

  task automatic wait_done(input int d, input bit who, input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(who ? done1[d] : done0[d]) && n < 40);
    if (!(who ? done1[d] : done0[d])) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s: got no done after %0d cycles, required done", nm, n);
    end
  endtask

  // Issue one operation, hold until done, drop req in the done cycle.
  task automatic run(input int d, input bit who, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ez, input logic eo);
    exp_t e;
    @(negedge clk);
    e.who = who; e.r = er; e.z = ez; e.o = eo;
    push(d, e);
    set_req(d, who, 1'b1, op, a, b);
    wait_done(d, who, "run");
    set_req(d, who, 1'b0, op, a, b);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n, last;
    rst = 2'b00; req0 = 2'b00; req1 = 2'b00;
    for (int d = 0; d < 2; d++) begin
      op0[d] = '0; op1[d] = '0; a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end

    // Asynchronous reset between edges.
    @(posedge clk);
    #2 rst = 2'b11;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_flags", {25'd0, gnt0[d], gnt1[d], done0[d], done1[d], zero[d], ovf[d], busy[d]}, '0);
      chk("rst_r", r[d], '0);
    end
    @(negedge clk) rst = 2'b00;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 2; d++)
      chk("idle_after_rst", {29'd0, busy[d], gnt0[d], gnt1[d]}, '0);

    // LAT=1 directed vectors.
    run(0, 0, XOR_, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 0, 0);
    run(0, 0, XOR_, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run(0, 1, ADD_, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1);
    run(0, 1, SUB_, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1);
    run(0, 0, SLT_, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 0, 0);
    run(0, 1, SLT_, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);
    run(0, 0, AND_, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 0);
    run(0, 1, NOR_, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0);
    run(0, 0, ADD_, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
    run(0, 1, SUB_, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0);
    run(0, 0, OR_,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 0);
    run(0, 1, PASS_, 32'h1234_5678, 32'h0000_0009, 32'h1234_5678, 0, 0);
    repeat (3) @(negedge clk);
    chk("r_hold", r[0], 32'h1234_5678);

    // Round-robin with both requests held, starting from a fresh pointer.
    @(negedge clk) rst[0] = 1'b1;
    @(negedge clk) rst[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.who = i[0];
      e.r   = i[0] ? 32'h0000_00FF : 32'h0000_0003;
      e.z   = 1'b0;
      e.o   = 1'b0;
      push(0, e);
    end
    set_req(0, 0, 1'b1, ADD_, 32'h1, 32'h2);
    set_req(0, 1, 1'b1, OR_, 32'hF0, 32'h0F);
    last = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(done0[0] | done1[0]) && n < 20);
      if (!(done0[0] | done1[0])) begin
        checks++;
        failures++;
        $display("FAIL rr_timeout: got no done, required done %0d", i);
      end else if (i > 0) begin
        chk("rr_spacing", cyc - last, 32'd3);
      end
      last = cyc;
    end
    req0[0] = 1'b0;
    req1[0] = 1'b0;

    // LAT=4: plain operation, then operand capture.
    run(1, 0, ADD_, 32'h0000_0100, 32'h0000_0023, 32'h0000_0123, 0, 0);
    @(negedge clk);
    e.who = 0; e.r = 32'h0000_000D; e.z = 0; e.o = 0;
    push(1, e);
    set_req(1, 0, 1'b1, ADD_, 32'd10, 32'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0[1] && n < 20);
    chk("cap_gnt", {31'd0, gnt0[1]}, 32'd1);
    a0[1] = 32'hFFFF_0000;
    b0[1] = 32'h0000_FFFF;
    wait_done(1, 0, "capture");
    req0[1] = 1'b0;

    // Reset abort in the 2nd EXEC cycle; pointer (now 1) must return to 0.
    @(negedge clk);
    set_req(1, 1, 1'b1, PASS_, 32'hDEAD_BEEF, 32'h0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt1[1] && n < 20);
    chk("abort_gnt", {31'd0, gnt1[1]}, 32'd1);
    @(negedge clk);
    rst[1] = 1'b1;
    req1[1] = 1'b0;
    #1;
    chk("abort_state", {30'd0, gnt1[1], busy[1]}, '0);
    @(negedge clk) rst[1] = 1'b0;
    repeat (8) @(negedge clk);
    e.who = 0; e.r = 32'h0000_000F; e.z = 0; e.o = 0;
    push(1, e);
    set_req(1, 0, 1'b1, XOR_, 32'hF0, 32'hFF);
    set_req(1, 1, 1'b1, AND_, 32'hF0, 32'hFF);
    wait_done(1, 0, "post_abort");
    req0[1] = 1'b0;
    req1[1] = 1'b0;
    repeat (6) @(negedge clk);

    chk("q_empty", q0.size() + q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
